// File: rtl/spwm_gate_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spwm_gate_gen_pkg                                                |
// | Purpose  : Shared constants and types for the three-phase SPWM gate        |
// |            generator: Q1.15 reference constants, carrier direction         |
// |            encoding and the Q1.15 -> offset-binary helper.                 |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package spwm_gate_gen_pkg;

  // Q1.15 modulation index extremes and the bias that maps the signed range
  // [-1, +1) onto the unsigned range [0, 65536).
  localparam logic [15:0] Q15_MAX    = 16'h7FFF;
  localparam logic [15:0] Q15_MIN    = 16'h8000;
  localparam int unsigned Q15_OFFSET = 32768;

  // Carrier slope. DIR_UP is the reset direction so the first step from the
  // valley is upward.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Adding 32768 to a 16-bit two's complement value and reading the result as
  // unsigned is the same as inverting the sign bit.
  function automatic logic [15:0] q15_to_offset(input logic [15:0] q15);
    return q15 ^ Q15_MIN;
  endfunction

endpackage : spwm_gate_gen_pkg
`default_nettype wire

// File: rtl/spwm_thr_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spwm_thr_calc                                                   |
// | Purpose  : Converts one signed Q1.15 modulation index into an unsigned     |
// |            compare threshold for a symmetric carrier of peak PERIOD and    |
// |            holds it as the shadow threshold of that phase.                 |
// |              thr = ((ref + 32768) * PERIOD + 32768) >> 16                  |
// |            with +full scale saturating to PERIOD+1 (gate always on) and    |
// |            -full scale to 0 (gate always off).                             |
// | Ports    : clk     in   system clock                                       |
// |            rst     in   asynchronous active-high reset                     |
// |            clr     in   synchronous clear (same end state as rst)          |
// |            load    in   capture strobe for ref_in                          |
// |            ref_in  in   signed Q1.15 modulation index                      |
// |            thr     out  registered threshold, CNT_W+1 bits                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spwm_thr_calc
  import spwm_gate_gen_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 2500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [15:0]      ref_in,
  output logic [CNT_W:0]   thr
);

  localparam int THR_W  = CNT_W + 1;
  // Product of a 16-bit offset value and a CNT_W-bit period, plus one bit of
  // headroom for the rounding constant.
  localparam int PROD_W = 16 + CNT_W + 1;

  localparam logic [THR_W-1:0]  THR_FULL   = THR_W'(PERIOD + 1);
  localparam logic [PROD_W-1:0] PERIOD_EXT = PROD_W'(PERIOD);
  localparam logic [PROD_W-1:0] ROUND_EXT  = PROD_W'(Q15_OFFSET);

  logic [PROD_W-1:0] offset_w;
  logic [PROD_W-1:0] product_w;
  logic [PROD_W-1:0] rounded_w;
  logic [THR_W-1:0]  scaled_w;
  logic [15:0]       unused_lsbs;

  logic [THR_W-1:0]  thr_d;
  logic [THR_W-1:0]  thr_q;

  // Scale the biased reference by the carrier peak and round to nearest.
  // The upper bits after the >>16 fit THR_W exactly because PERIOD < 2^CNT_W.
  assign offset_w    = PROD_W'(q15_to_offset(ref_in));
  assign product_w   = offset_w * PERIOD_EXT;
  assign rounded_w   = product_w + ROUND_EXT;
  assign scaled_w    = rounded_w[PROD_W-1:16];
  assign unused_lsbs = rounded_w[15:0];

  always_comb begin
    thr_d = thr_q;
    if (load) begin
      // The extremes are pinned so that full modulation really holds the gate
      // on (or off) for the whole carrier period instead of leaving a single
      // cycle of the opposite state at the peak.
      if (ref_in == Q15_MAX) begin
        thr_d = THR_FULL;
      end else if (ref_in == Q15_MIN) begin
        thr_d = '0;
      end else begin
        thr_d = scaled_w;
      end
    end
    if (clr) begin
      thr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= '0;
    end else begin
      thr_q <= thr_d;
    end
  end

  assign thr = thr_q;

endmodule : spwm_thr_calc
`default_nettype wire

// File: rtl/spwm_gate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spwm_gate_gen                                                   |
// | Purpose  : Three-phase sinusoidal PWM gate generator. A shared symmetric   |
// |            up-down carrier (0..PERIOD..0, period 2*PERIOD clocks) is       |
// |            compared against one threshold per phase to produce the upper   |
// |            switch gates. New references land in per-phase shadow           |
// |            registers and are promoted to the active thresholds only at     |
// |            the carrier valley, so a gate never changes duty mid-period.    |
// |            Valley and peak strobes mark the solver step start.             |
// | Ports    : clk         in   system clock                                   |
// |            rst         in   asynchronous active-high reset                 |
// |            rst_user    in   synchronous clear, same end state as rst       |
// |            en          in   carrier run enable                             |
// |            ref_load    in   one-cycle strobe capturing ref_a/b/c           |
// |            ref_a/b/c   in   per-phase modulation index, signed Q1.15       |
// |            pwm_1/3/5   out  phase a/b/c upper gate                         |
// |            sta_valley  out  one-cycle pulse, carrier was at 0              |
// |            sta_peak    out  one-cycle pulse, carrier was at PERIOD         |
// |            carrier     out  current carrier count                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spwm_gate_gen
  import spwm_gate_gen_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 2500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_user,
  input  logic             en,
  input  logic             ref_load,
  input  logic [15:0]      ref_a,
  input  logic [15:0]      ref_b,
  input  logic [15:0]      ref_c,
  output logic             pwm_1,
  output logic             pwm_3,
  output logic             pwm_5,
  output logic             sta_valley,
  output logic             sta_peak,
  output logic [CNT_W-1:0] carrier
);

  localparam int               THR_W  = CNT_W + 1;
  localparam int               N_PH   = 3;
  localparam logic [CNT_W-1:0] CNT_PK = CNT_W'(PERIOD);

  // ---------------------------------------------------------------------------
  // Per-phase shadow thresholds
  // ---------------------------------------------------------------------------
  logic [N_PH-1:0][15:0]      ref_w;
  logic [N_PH-1:0][THR_W-1:0] shadow_w;

  assign ref_w = {ref_c, ref_b, ref_a};

  generate
    for (genvar gi = 0; gi < N_PH; gi++) begin : g_phase
      spwm_thr_calc #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
      ) u_thr_calc (
        .clk    (clk),
        .rst    (rst),
        .clr    (rst_user),
        .load   (ref_load),
        .ref_in (ref_w[gi]),
        .thr    (shadow_w[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]           cnt_d,        cnt_q;
  dir_e                       dir_d,        dir_q;
  logic                       pending_d,    pending_q;
  logic [N_PH-1:0][THR_W-1:0] active_d,     active_q;
  logic [N_PH-1:0]            pwm_d,        pwm_q;
  logic                       sta_valley_d, sta_valley_q;
  logic                       sta_peak_d,   sta_peak_q;

  logic                       at_valley_w;
  logic                       at_peak_w;
  logic                       apply_w;
  logic [N_PH-1:0][THR_W-1:0] thr_eff_w;

  assign at_valley_w = (cnt_q == '0);
  assign at_peak_w   = (cnt_q == CNT_PK);

  // A pending shadow is promoted only while the carrier is running and sits
  // at the valley; this is the one point in the period where both gate edges
  // of the old duty have already happened.
  assign apply_w = en & at_valley_w & pending_q;

  // ---------------------------------------------------------------------------
  // Carrier counter
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (en) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q < CNT_PK) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Turn around at the peak without dwelling, so PERIOD is visited once.
          cnt_d = cnt_q - 1'b1;
          dir_d = DIR_DOWN;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          dir_d = DIR_UP;
        end
      end
    end
    if (rst_user) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold promotion, compare and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // A load in the same cycle as the valley re-arms pending for the next
    // valley while the previously pending shadow is promoted now; the shadow
    // register still holds that older value during this cycle.
    pending_d = ref_load | (pending_q & ~apply_w);

    for (int i = 0; i < N_PH; i++) begin
      // Bypass: the valley compare already sees the freshly promoted value,
      // which keeps the new duty centred on this valley.
      thr_eff_w[i] = apply_w ? shadow_w[i] : active_q[i];
      active_d[i]  = thr_eff_w[i];
      pwm_d[i]     = en & ({1'b0, cnt_q} < thr_eff_w[i]);
    end

    sta_valley_d = en & at_valley_w;
    sta_peak_d   = en & at_peak_w;

    if (rst_user) begin
      pending_d    = 1'b0;
      active_d     = '0;
      pwm_d        = '0;
      sta_valley_d = 1'b0;
      sta_peak_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      pending_q    <= 1'b0;
      active_q     <= '0;
      pwm_q        <= '0;
      sta_valley_q <= 1'b0;
      sta_peak_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      pwm_q        <= pwm_d;
      sta_valley_q <= sta_valley_d;
      sta_peak_q   <= sta_peak_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pwm_1      = pwm_q[0];
  assign pwm_3      = pwm_q[1];
  assign pwm_5      = pwm_q[2];
  assign sta_valley = sta_valley_q;
  assign sta_peak   = sta_peak_q;
  assign carrier    = cnt_q;

endmodule : spwm_gate_gen
`default_nettype wire

// File: tb/tb_spwm_gate_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_spwm_gate_gen                                                |
// | Purpose  : Self-checking bench for spwm_gate_gen with PERIOD=10.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spwm_gate_gen;

  localparam int CNT_W  = 16;
  localparam int PERIOD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             rst_user;
  logic             en;
  logic             ref_load;
  logic [15:0]      ref_a;
  logic [15:0]      ref_b;
  logic [15:0]      ref_c;
  logic             pwm_1;
  logic             pwm_3;
  logic             pwm_5;
  logic             sta_valley;
  logic             sta_peak;
  logic [CNT_W-1:0] carrier;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spwm_gate_gen #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_user   (rst_user),
    .en         (en),
    .ref_load   (ref_load),
    .ref_a      (ref_a),
    .ref_b      (ref_b),
    .ref_c      (ref_c),
    .pwm_1      (pwm_1),
    .pwm_3      (pwm_3),
    .pwm_5      (pwm_5),
    .sta_valley (sta_valley),
    .sta_peak   (sta_peak),
    .carrier    (carrier)
  );

  typedef struct {
    logic [15:0] ra, rb, rc;
    int          ta, tb, tc;   // expected thresholds
    int          ha, hb, hc;   // expected high cycles per carrier period
  } vec_t;

  vec_t vecs [4];

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_refs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    ref_a    = a;
    ref_b    = b;
    ref_c    = c;
    ref_load = 1'b1;
    tick();
    ref_load = 1'b0;
  endtask

  // sel 0: carrier == val, 1: sta_valley, 2: sta_peak
  task automatic wait_until(input int sel, input int val, input string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      case (sel)
        0:       hit = (int'(carrier) == val);
        1:       hit = sta_valley;
        default: hit = sta_peak;
      endcase
      if (!hit) tick();
    end
    check({name, " wait"}, int'(hit), 1);
  endtask

  // Starts on the sample where sta_valley is high and observes one full
  // period; returns on the next valley sample.
  task automatic measure(input string tag, input int ta, input int tb, input int tc,
                         output int ha, output int hb, output int hc);
    int c, ea, eb, ec, es;
    ha = 0; hb = 0; hc = 0;
    ea = 0; eb = 0; ec = 0; es = 0;
    for (int i = 0; i < 2*PERIOD; i++) begin
      c = (i <= PERIOD) ? i : 2*PERIOD - i;
      ha += int'(pwm_1);
      hb += int'(pwm_3);
      hc += int'(pwm_5);
      if (int'(pwm_1) != int'(c < ta)) ea++;
      if (int'(pwm_3) != int'(c < tb)) eb++;
      if (int'(pwm_5) != int'(c < tc)) ec++;
      if (int'(sta_valley) != int'(i == 0) || int'(sta_peak) != int'(i == PERIOD)) es++;
      tick();
    end
    check({tag, " pattern_a"}, ea, 0);
    check({tag, " pattern_b"}, eb, 0);
    check({tag, " pattern_c"}, ec, 0);
    check({tag, " strobes"},   es, 0);
  endtask

  initial begin
    int ha, hb, hc, p, hi;

    vecs[0] = '{ra:16'h0000, rb:16'h7FFF, rc:16'h8000, ta:5, tb:11, tc:0,  ha:9,  hb:20, hc:0};
    vecs[1] = '{ra:16'h4000, rb:16'hC000, rc:16'h7FFE, ta:8, tb:3,  tc:10, ha:15, hb:5,  hc:19};
    vecs[2] = '{ra:16'h2000, rb:16'hE000, rc:16'h8001, ta:6, tb:4,  tc:0,  ha:11, hb:7,  hc:0};
    vecs[3] = '{ra:16'h8000, rb:16'h0000, rc:16'h7FFF, ta:0, tb:5,  tc:11, ha:0,  hb:9,  hc:20};

    rst = 1'b1; rst_user = 1'b0; en = 1'b0; ref_load = 1'b0;
    ref_a = '0; ref_b = '0; ref_c = '0;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset / idle with en=0
    for (int k = 0; k < 50; k++) begin
      tick();
      check("idle carrier", int'(carrier), 0);
      check("idle outputs", int'({pwm_1, pwm_3, pwm_5, sta_valley, sta_peak}), 0);
    end

    // Carrier shape from reset: 1,2..10,9..1,0,1..
    en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      p = k % 20;
      check("shape carrier", int'(carrier), (p <= 10) ? p : 20 - p);
      check("shape valley",  int'(sta_valley), int'(p == 1));
      check("shape peak",    int'(sta_peak),   int'(p == 11));
      check("shape pwm",     int'({pwm_1, pwm_3, pwm_5}), 0);
    end

    // Table-driven thresholds
    foreach (vecs[v]) begin
      load_refs(vecs[v].ra, vecs[v].rb, vecs[v].rc);
      tick();
      wait_until(1, 0, "vec valley");
      measure("vec", vecs[v].ta, vecs[v].tb, vecs[v].tc, ha, hb, hc);
      check("vec high_a", ha, vecs[v].ha);
      check("vec high_b", hb, vecs[v].hb);
      check("vec high_c", hc, vecs[v].hc);
    end

    // Shadow timing: two loads mid-period, only the last lands at the valley
    wait_until(2, 0, "shadow peak");
    tick(); tick();
    load_refs(16'h0000, 16'h0000, 16'h7FFF);
    tick();
    load_refs(16'h4000, 16'h0000, 16'h7FFF);
    hi = 0;
    for (int k = 0; k < 40 && !sta_valley; k++) begin
      hi += int'(pwm_1);
      tick();
    end
    check("shadow early pwm_1", hi, 0);
    wait_until(1, 0, "shadow valley");
    measure("shadow", 8, 5, 11, ha, hb, hc);
    check("shadow high_a", ha, 15);

    // Saturation over several periods
    load_refs(16'h0000, 16'h7FFF, 16'h8000);
    tick();
    wait_until(1, 0, "sat valley");
    for (int r = 0; r < 3; r++) begin
      measure("sat", 5, 11, 0, ha, hb, hc);
      check("sat high_a", ha, 9);
      check("sat high_b", hb, 20);
      check("sat high_c", hc, 0);
    end

    // Load coinciding with the valley: older pending applies first
    load_refs(16'hC000, 16'h0000, 16'h0000);
    wait_until(0, 0, "coin carrier0");
    load_refs(16'h7FFF, 16'h7FFF, 16'h8000);
    check("coin valley strobe", int'(sta_valley), 1);
    measure("coin first", 3, 5, 5, ha, hb, hc);
    check("coin first high_a", ha, 5);
    measure("coin second", 11, 11, 0, ha, hb, hc);
    check("coin second high_a", ha, 20);
    check("coin second high_c", hc, 0);

    // Enable drop at carrier 6 on the up slope, with a load while disabled
    wait_until(0, 6, "en cnt6");
    check("en pre pwm_1", int'(pwm_1), 1);
    en = 1'b0;
    tick();
    check("en hold carrier", int'(carrier), 6);
    check("en off pwm", int'({pwm_1, pwm_3, pwm_5}), 0);
    check("en off sta", int'({sta_valley, sta_peak}), 0);
    load_refs(16'h8000, 16'h0000, 16'h7FFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("en hold carrier", int'(carrier), 6);
      check("en off pwm", int'({pwm_1, pwm_3, pwm_5}), 0);
    end
    en = 1'b1;
    tick();
    check("en resume carrier", int'(carrier), 7);
    check("en resume pwm_1", int'(pwm_1), 1);
    tick();
    check("en resume carrier2", int'(carrier), 8);
    wait_until(1, 0, "en valley");
    measure("en load", 0, 5, 11, ha, hb, hc);
    check("en load high_a", ha, 0);

    // rst_user mid-period with a pending load
    load_refs(16'h7FFF, 16'h7FFF, 16'h7FFF);
    tick(); tick();
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    check("clr carrier", int'(carrier), 0);
    check("clr outputs", int'({pwm_1, pwm_3, pwm_5, sta_valley, sta_peak}), 0);
    tick();
    check("clr restart carrier", int'(carrier), 1);
    check("clr restart valley", int'(sta_valley), 1);
    for (int r = 0; r < 2; r++) begin
      measure("clr", 0, 0, 0, ha, hb, hc);
      check("clr high_sum", ha + hb + hc, 0);
    end

    // Asynchronous rst mid-period
    load_refs(16'h7FFF, 16'h7FFF, 16'h7FFF);
    tick();
    wait_until(1, 0, "arst valley");
    wait_until(0, 4, "arst cnt4");
    check("arst pre pwm_1", int'(pwm_1), 1);
    load_refs(16'h0000, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    #1;
    check("arst carrier", int'(carrier), 0);
    check("arst outputs", int'({pwm_1, pwm_3, pwm_5, sta_valley, sta_peak}), 0);
    tick();
    rst = 1'b0;
    tick();
    wait_until(1, 0, "arst valley2");
    measure("arst", 0, 0, 0, ha, hb, hc);
    check("arst high_sum", ha + hb + hc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spwm_gate_gen
`default_nettype wire

// File: doc/spwm_gate_gen.md
Name: spwm_gate_gen

Overview:
- Three-phase sinusoidal-PWM gate generator: the producing end of the pwm_1/pwm_3/pwm_5 gate interface consumed by the switching-function inverter source models.
- Takes per-phase modulation references from the controller solver and compares them against a shared symmetric up-down triangular carrier.
- Emits the three upper-switch gate signals, plus carrier valley/peak strobes that the solver uses as its step-start (sta) timing.

Parameters:
- CNT_W, 16, carrier counter width.
- PERIOD, 2500, carrier peak count; carrier period = 2*PERIOD clk cycles; legal range 2..2^CNT_W-2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rst_user  in  1  synchronous clear; same end state as rst.
- en  in  1  carrier run enable.
- ref_load  in  1  one-cycle strobe; captures ref_a/ref_b/ref_c.
- ref_a  in  16  phase-a modulation index, signed Q1.15.
- ref_b  in  16  phase-b modulation index, signed Q1.15.
- ref_c  in  16  phase-c modulation index, signed Q1.15.
- pwm_1  out  1  phase-a upper gate.
- pwm_3  out  1  phase-b upper gate.
- pwm_5  out  1  phase-c upper gate.
- sta_valley  out  1  one-cycle pulse; carrier at 0.
- sta_peak  out  1  one-cycle pulse; carrier at PERIOD.
- carrier  out  CNT_W  current carrier count.

Behaviour:
- Reset (rst or rst_user):
  - Outputs: cnt=0, dir=up, pwm_*=0, sta_*=0.
  - Internal: active and shadow thresholds = 0, pending=0.
- Carrier, advancing only when en=1:
  - up: cnt<PERIOD -> cnt+1; cnt==PERIOD -> cnt-1 and dir=down.
  - down: cnt>0 -> cnt-1; cnt==0 -> cnt+1 and dir=up.
  - Resulting sequence: 0,1..PERIOD..1,0,1..
- en=0:
  - cnt and dir hold.
  - pwm_* forced 0 on the next edge.
  - sta_* = 0.
  - ref_load is still accepted.
- Threshold computation, one pipeline stage after ref_load:
  - thr = ((ref + 32768) * PERIOD + 32768) >> 16, as unsigned.
  - Special case ref == 16'h7FFF -> thr = PERIOD+1 (full on).
  - Special case ref == 16'h8000 -> thr = 0 (full off).
  - thr is CNT_W+1 bits wide.
- Shadow/pending:
  - ref_load at cycle t -> shadow thresholds written and pending=1 at t+1.
  - A new ref_load overwrites the shadow (last-wins).
- Active update at valley only:
  - When en=1, cnt==0 and pending=1: active thr <= shadow thr, and pending clears.
  - The comparison in that same valley cycle already uses the new value (bypass mux).
  - If ref_load coincides with the valley, the previously pending value applies; the new one stays pending until the next valley.
- Compare:
  - pwm_x <= en & (cnt < thr_x), registered, with 1-cycle latency from the carrier value.
  - High cycles per carrier period = 0 if thr=0; 2*thr-1 for 1<=thr<=PERIOD; 2*PERIOD if thr=PERIOD+1.
- Strobes:
  - sta_valley <= en & (cnt==0).
  - sta_peak <= en & (cnt==PERIOD).
  - Both are registered, aligned with pwm_*.
- Never glitch mid-period: active thresholds change only at a valley.
- rst asserted mid-period: everything returns to reset state immediately; pending refs are lost.

Decomposition:
- Shared package/include:
  - Q1.15 constants (Q15_MAX=16'h7FFF, Q15_MIN=16'h8000, Q15_OFFSET=32768).
  - Carrier direction encoding (DIR_UP=1'b1, DIR_DOWN=1'b0).
- One natural sub-module, spwm_thr_calc:
  - Q1.15 -> unsigned threshold conversion with saturation, registered.
  - Instantiated three times.
- Carrier counter and compare stay in the top level.

Test Plan:
- Reset/idle:
  - Stimulus: PERIOD=10; rst pulse, en=0 for 50 cycles.
  - Required: carrier=0, pwm_*=0, sta_*=0 throughout.
- Carrier shape:
  - Stimulus: PERIOD=10, en=1.
  - Required: carrier 0..10..1 repeating; sta_valley every 20 cycles; sta_peak every 20 cycles, offset 10 from valley.
- Mid duty:
  - Stimulus: PERIOD=10; ref_a=0 loaded before a valley.
  - Required: thr=5; pwm_1 high 9 of every 20 cycles, centred on the valley, changing at the first valley after the load.
- Saturation:
  - Stimulus: ref_b=16'h7FFF, ref_c=16'h8000.
  - Required: after the next valley, pwm_3 constant 1 and pwm_5 constant 0 across several periods.
- Shadow timing:
  - Stimulus: ref_load with ref_a=0 mid-period, then ref_a=16'h4000 two cycles later.
  - Required: the active duty does not change until the valley; then thr=8 (15 high cycles); the intermediate value is never applied.
- Enable/reset mid-run:
  - Stimulus: drop en at cnt=6.
  - Required: carrier holds 6, pwm_* go 0 next cycle, and counting resumes from 6 on re-enable.
  - Stimulus: rst_user pulse.
  - Required: cnt=0, pending cleared, thr=0.
